// File: rtl/adrv9001_tdd_sched.sv
// rtl/adrv9001_tdd_sched.sv - TDD frame scheduler driving ADRV9001 channel and SSI enables
module adrv9001_tdd_sched #(
    parameter int CNTR_W = 24,
    parameter int DLY_W  = 16
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_areset,
    input  logic                run,
    input  logic                abort,
    input  logic [CNTR_W-1:0]   frame_len,
    input  logic [15:0]         num_frames,
    input  logic [4*CNTR_W-1:0] en_on,
    input  logic [4*CNTR_W-1:0] en_off,
    input  logic [4*DLY_W-1:0]  ssi_dly,
    output logic [3:0]          ch_en,
    output logic [3:0]          ssi_en,
    output logic                busy,
    output logic                frame_strobe,
    output logic [15:0]         frame_cnt,
    output logic                done,
    output logic                cfg_err
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                run_q;
    logic [CNTR_W-1:0]   t;
    logic [CNTR_W-1:0]   len_s;
    logic [15:0]         nfr_s;
    logic [4*CNTR_W-1:0] on_s;
    logic [4*CNTR_W-1:0] off_s;
    logic [4*DLY_W-1:0]  dly_s;
    logic [DLY_W-1:0]    ssi_cnt [4];
    logic [3:0]          ch_en_nxt;
    logic                run_edge;
    logic                last_cycle;
    logic                last_frame;
    logic                frame_exit;

    assign run_edge   = run && !run_q;
    assign last_cycle = (t == len_s - CNTR_W'(1));
    // run is sampled live so a drop anywhere in the frame ends the sequence at its close
    assign last_frame = ((nfr_s != 16'd0) && (frame_cnt + 16'd1 == nfr_s)) || !run;
    assign frame_exit = (state == RUN) && last_cycle && last_frame;

    assign busy         = (state != IDLE);
    assign frame_strobe = (state == RUN) && (t == '0);
    assign done         = (state == STOP);

    // State register
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next channel enables; abort overrides every transition
    always_comb begin
        state_nxt = state;
        ch_en_nxt = '0;
        case (state)
            IDLE:    if (run_edge && (frame_len != '0)) state_nxt = ARM;
            ARM:     state_nxt = RUN;
            RUN:     if (frame_exit) state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
        for (int ch = 0; ch < 4; ch++) begin
            ch_en_nxt[ch] = (state == RUN) && !frame_exit && !abort &&
                            (t >= on_s[ch*CNTR_W +: CNTR_W]) &&
                            (t <  off_s[ch*CNTR_W +: CNTR_W]);
        end
    end

    // Run-edge history, frame timer, frame counter, shadow config and start-rejection pulse
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            run_q     <= 1'b0;
            t         <= '0;
            frame_cnt <= '0;
            cfg_err   <= 1'b0;
            len_s     <= '0;
            nfr_s     <= '0;
            on_s      <= '0;
            off_s     <= '0;
            dly_s     <= '0;
        end else begin
            run_q   <= run;
            cfg_err <= (state == IDLE) && run_edge && (frame_len == '0) && !abort;
            if (!abort) begin
                if (state == ARM) begin
                    len_s     <= frame_len;
                    nfr_s     <= num_frames;
                    on_s      <= en_on;
                    off_s     <= en_off;
                    dly_s     <= ssi_dly;
                    t         <= '0;
                    frame_cnt <= '0;
                end else if (state == RUN) begin
                    if (last_cycle) begin
                        t         <= '0;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        t <= t + CNTR_W'(1);
                    end
                end
            end
        end
    end

    // Registered channel enables and per-channel SSI settle counters (restart only on a rise)
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            ch_en <= '0;
            for (int ch = 0; ch < 4; ch++) begin
                ssi_cnt[ch] <= '0;
            end
        end else begin
            ch_en <= ch_en_nxt;
            for (int ch = 0; ch < 4; ch++) begin
                if (ch_en_nxt[ch] && !ch_en[ch]) begin
                    ssi_cnt[ch] <= '0;
                end else if (ch_en[ch] && (ssi_cnt[ch] != dly_s[ch*DLY_W +: DLY_W])) begin
                    ssi_cnt[ch] <= ssi_cnt[ch] + DLY_W'(1);
                end
            end
        end
    end

    // SSI enable follows ch_en once the settle count has reached the programmed delay
    always_comb begin
        ssi_en = '0;
        for (int ch = 0; ch < 4; ch++) begin
            ssi_en[ch] = ch_en[ch] && (ssi_cnt[ch] == dly_s[ch*DLY_W +: DLY_W]);
        end
    end

endmodule
